// File: rtl/four_bit_serial_subtractor.sv
// Bit-serial 4-bit subtractor (Diff = A - B - Bin), LSB first, with Start/Busy/Done handshake.
// Optional Zero/Ovf status outputs are enabled by defining SUBTRACTOR_FLAGS_EN.
module four_bit_serial_subtractor (
  input  logic Clk,
  input  logic Rst,
  input  logic Start,
  input  logic A3,
  input  logic A2,
  input  logic A1,
  input  logic A0,
  input  logic B3,
  input  logic B2,
  input  logic B1,
  input  logic B0,
  input  logic Bin,
  output logic Busy,
  output logic Done,
  output logic Diff3,
  output logic Diff2,
  output logic Diff1,
  output logic Diff0,
  output logic Bout
`ifdef SUBTRACTOR_FLAGS_EN
  ,
  output logic Zero,
  output logic Ovf
`endif
);

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 2;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, d_q, d_d;
  logic            br_q, br_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [W-1:0]    diff_q, diff_d;
  logic            bout_q, bout_d;

  // Single full-subtractor cell on the current LSBs
  logic            a_i, b_i, d_bit, br_nxt;
  logic [W-1:0]    d_shift;

  assign a_i     = a_q[0];
  assign b_i     = b_q[0];
  assign d_bit   = a_i ^ b_i ^ br_q;
  assign br_nxt  = (~a_i & b_i) | (~(a_i ^ b_i) & br_q);
  assign d_shift = {d_bit, d_q[W-1:1]};

`ifdef SUBTRACTOR_FLAGS_EN
  logic zero_q, zero_d, ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    br_d    = br_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SUBTRACTOR_FLAGS_EN
    zero_d  = zero_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          a_d     = {A3, A2, A1, A0};
          b_d     = {B3, B2, B1, B0};
          d_d     = '0;
          br_d    = Bin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        busy_d = 1'b1;
        a_d    = {1'b0, a_q[W-1:1]};
        b_d    = {1'b0, b_q[W-1:1]};
        d_d    = d_shift;
        br_d   = br_nxt;
        cnt_d  = CW'(cnt_q + 1'b1);
        // Last bit: a_i/b_i are the original MSBs, so overflow comes straight from them
        if (cnt_q == LAST) begin
          diff_d  = d_shift;
          bout_d  = br_nxt;
`ifdef SUBTRACTOR_FLAGS_EN
          zero_d  = (d_shift == '0);
          ovf_d   = (a_i ^ b_i) & (d_bit ^ a_i);
`endif
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      br_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SUBTRACTOR_FLAGS_EN
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      br_q    <= br_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SUBTRACTOR_FLAGS_EN
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign Busy  = busy_q;
  assign Done  = done_q;
  assign Diff3 = diff_q[3];
  assign Diff2 = diff_q[2];
  assign Diff1 = diff_q[1];
  assign Diff0 = diff_q[0];
  assign Bout  = bout_q;
`ifdef SUBTRACTOR_FLAGS_EN
  assign Zero  = zero_q;
  assign Ovf   = ovf_q;
`endif

endmodule
